lsu_mem_port: RTL and testbench

//  Load/store unit at the MEM stage: consumes mem_read/mem_write/funct3 from the control decoder and drives a
//  req/ack data-memory port. Builds byte enables and lane-aligned store data, sign/zero-extends load data,
//  and stalls the pipeline until the bus transaction completes.

---
 rtl/lsu_mem_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: MEM-stage load/store unit driving a req/ack data-memory port.
// It turns one load or store into one bus transaction and stalls the pipeline until the transaction finishes.
// On the way out it builds the byte enables and the lane-replicated store data.
// On the way back it selects the load byte or half and sign- or zero-extends it.
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
//   Defined:   a misaligned halfword or word access is trapped without touching the bus.
//   Undefined: the low address bits are masked to the access size and the access proceeds normally.

module lsu_mem_port #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            lsu_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            bus_err,
  output logic            misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_stateNext;

  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic             r_we;
  logic             r_isLoad;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_off;
  logic [4:0]       r_rd;
  logic [31:0]      r_wbData;
  logic             r_abort;
  logic [CNT_W-1:0] r_cnt;

  logic             w_start;
  logic [1:0]       w_size;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_loadData;
  logic             w_timeout;
  logic             w_req;
  logic             w_stall;
  logic             w_done;
  logic             w_trap;
  logic             w_trapped;

  assign w_start   = ex_mem_read | ex_mem_write;
  assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Decode the access size and format the store lanes. A read enables all four bytes.
  // For a halfword only addr[1] picks the lane, which is also what masks a misaligned address.
  always_comb begin
    w_size  = SZ_W;
    w_be    = 4'b1111;
    w_wdata = ex_wdata;
    case (ex_funct3)
      3'b000, 3'b100: w_size = SZ_B;
      3'b001, 3'b101: w_size = SZ_H;
      default:        w_size = SZ_W;
    endcase
    if (ex_mem_write) begin
      case (w_size)
        SZ_B: begin
          w_be    = 4'b0001 << ex_addr[1:0];
          w_wdata = {4{ex_wdata[7:0]}};
        end
        SZ_H: begin
          w_be    = 4'b0011 << {ex_addr[1], 1'b0};
          w_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_wdata;
        end
      endcase
    end
  end

  // Pick the addressed byte or half out of the returned word and extend it to 32 bits.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    w_loadData = dmem_rdata;
    case (r_off)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      SZ_B:    w_loadData = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      SZ_H:    w_loadData = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned = ((w_size == SZ_H) && ex_addr[0]) ||
                        ((w_size == SZ_W) && (ex_addr[1:0] != 2'b00));
  assign w_trap       = w_misaligned;
  assign w_trapped    = r_misalign;
  assign misalign_err = w_done & r_misalign;

  // Remember whether the access just accepted was trapped so that DONE can report it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_misalign <= w_start & w_misaligned;
    end
  end
`else
  assign w_trap       = 1'b0;
  assign w_trapped    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // State register for the IDLE -> REQ -> DONE transaction sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic and the per-state controls.
  // Stall drops in DONE so the pipeline advances while the result is written back.
  always_comb begin
    w_stateNext = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_start;
        if (w_start) begin
          w_stateNext = w_trap ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
        if (dmem_ack || w_timeout) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Latch the access when it is accepted and hold it stable while the request is outstanding.
  // In REQ, count the cycles and capture the load result on ack.
  // A timeout clears the result, but an ack in the last allowed cycle still completes the access normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_be     <= 4'h0;
      r_wdata  <= 32'h0;
      r_we     <= 1'b0;
      r_isLoad <= 1'b0;
      r_size   <= SZ_W;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_rd     <= 5'd0;
      r_wbData <= 32'h0;
      r_abort  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr   <= {ex_addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_we     <= ex_mem_write;
            r_isLoad <= ~ex_mem_write;
            r_size   <= w_size;
            r_signed <= ~ex_funct3[2];
            r_off    <= ex_addr[1:0];
            r_rd     <= ex_rd;
            r_abort  <= 1'b0;
            r_cnt    <= '0;
            if (w_trap) begin
              r_wbData <= 32'h0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_ack) begin
            if (r_isLoad) begin
              r_wbData <= w_loadData;
            end
          end else if (w_timeout) begin
            r_abort  <= 1'b1;
            r_wbData <= 32'h0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign lsu_stall  = w_stall;
  assign wb_valid   = w_done & r_isLoad & ~r_abort & ~w_trapped;
  assign wb_data    = r_wbData;
  assign wb_rd      = r_rd;
  assign bus_err    = w_done & r_abort;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: self-checking bench for lsu_mem_port.
// Each access is predicted from the load/store rules by a small behavioural model.
// Directed and random accesses are compared against the DUT cycle by cycle.

module tb_lsu_mem_port;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        lsu_stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        bus_err;
  logic        misalign_err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  lsu_mem_port #(.XLEN(32), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value and count the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Run one access and follow it through issue, the request cycles and the result cycle.
  // ackAt is the request cycle on which ack is returned; 0 means ack never arrives.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rdIdx, input int ackAt, input logic [31:0] rdata);
    int          size;
    int          cycles;
    bit          isLoad;
    bit          sgn;
    bit          trap;
    bit          abort;
    logic [31:0] expBe;
    logic [31:0] expWdata;
    logic [31:0] expLoad;
    logic [31:0] lane;

    isLoad = !wr;
    size   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
    sgn    = (f3 == 3'd0 || f3 == 3'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    trap   = (size == 2 && (addr % 2) != 0) || (size == 4 && (addr % 4) != 0);
`else
    trap   = 1'b0;
`endif
    abort  = !trap && (ackAt < 1 || ackAt > TIMEOUT);

    expBe    = 32'd15;
    expWdata = wdata;
    if (wr) begin
      if (size == 1) begin
        expBe    = 32'd1 << (addr % 4);
        expWdata = (wdata & 32'hFF) * 32'h01010101;
      end else if (size == 2) begin
        expBe    = 32'd3 << (((addr % 4) >= 2) ? 2 : 0);
        expWdata = (wdata & 32'hFFFF) * 32'h00010001;
      end
    end

    expLoad = rdata;
    if (size == 1) begin
      lane = (rdata >> (8 * (addr % 4))) & 32'hFF;
      expLoad = (sgn && lane >= 128) ? lane - 32'd256 : lane;
    end else if (size == 2) begin
      lane = (rdata >> ((((addr % 4) >= 2)) ? 16 : 0)) & 32'hFFFF;
      expLoad = (sgn && lane >= 32768) ? lane - 32'd65536 : lane;
    end

    @(negedge clk);
    ex_mem_write = wr;
    ex_mem_read  = rd;
    ex_funct3    = f3;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_rd        = rdIdx;
    dmem_ack     = 1'b0;
    #1;
    checkOutput("stall_issue", lsu_stall, 1);
    checkOutput("req_issue", dmem_req, 0);

    if (trap) begin
      @(negedge clk);
      #1;
      checkOutput("trap_misalign", misalign_err, 1);
      checkOutput("trap_req", dmem_req, 0);
      checkOutput("trap_stall", lsu_stall, 0);
      checkOutput("trap_wbvalid", wb_valid, 0);
      checkOutput("trap_buserr", bus_err, 0);
    end else begin
      cycles = abort ? TIMEOUT : ackAt;
      for (int c = 1; c <= cycles; c++) begin
        @(negedge clk);
        dmem_ack   = (c == ackAt);
        dmem_rdata = (c == ackAt) ? rdata : $urandom;
        #1;
        checkOutput("req_high", dmem_req, 1);
        checkOutput("stall_req", lsu_stall, 1);
        if (c == 1) begin
          checkOutput("addr", dmem_addr, addr & 32'hFFFFFFFC);
          checkOutput("we", dmem_we, wr);
          checkOutput("be", dmem_be, expBe);
          if (wr) begin
            checkOutput("wdata", dmem_wdata, expWdata);
          end
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      checkOutput("done_req", dmem_req, 0);
      checkOutput("done_stall", lsu_stall, 0);
      checkOutput("done_wbvalid", wb_valid, isLoad && !abort);
      checkOutput("done_buserr", bus_err, abort);
      checkOutput("done_misalign", misalign_err, 0);
      if (isLoad && !abort) begin
        checkOutput("wb_data", wb_data, expLoad);
        checkOutput("wb_rd", wb_rd, rdIdx);
      end
      if (abort) begin
        checkOutput("abort_wbdata", wb_data, 0);
      end
    end
  endtask

  // One quiet cycle with no memory operation presented.
  task automatic idleCycle();
    @(negedge clk);
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    dmem_ack     = 1'b0;
    #1;
    checkOutput("idle_stall", lsu_stall, 0);
    checkOutput("idle_req", dmem_req, 0);
  endtask

  // Reset lands while a request is outstanding; an ack arriving afterwards must be ignored.
  task automatic resetMidTransaction();
    @(negedge clk);
    ex_mem_read  = 1'b1;
    ex_mem_write = 1'b0;
    ex_funct3    = 3'b010;
    ex_addr      = 32'h0000_0300;
    ex_rd        = 5'd7;
    @(negedge clk);
    #1;
    checkOutput("rstmid_req_before", dmem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    ex_mem_read  = 1'b0;
    dmem_ack     = 1'b1;
    dmem_rdata   = 32'h1111_2222;
    #1;
    checkOutput("rstmid_req_after", dmem_req, 0);
    checkOutput("rstmid_wbvalid", wb_valid, 0);
    checkOutput("rstmid_stall", lsu_stall, 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    checkOutput("rstmid_late_ack_wbvalid", wb_valid, 0);
    checkOutput("rstmid_late_ack_req", dmem_req, 0);
    checkOutput("rstmid_late_ack_buserr", bus_err, 0);
  endtask

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed cases, then randomized accesses.
  initial begin
    logic [2:0] f3Pick [0:7];
    logic [2:0] f3;
    logic       wr;
    logic       rd;
    f3Pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};

    rst          = 1'b1;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_funct3    = 3'b000;
    ex_addr      = 32'h0;
    ex_wdata     = 32'h0;
    ex_rd        = 5'd0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", dmem_req, 0);
    checkOutput("rst_we", dmem_we, 0);
    checkOutput("rst_addr", dmem_addr, 0);
    checkOutput("rst_be", dmem_be, 0);
    checkOutput("rst_wdata", dmem_wdata, 0);
    checkOutput("rst_wbdata", wb_data, 0);
    checkOutput("rst_wbrd", wb_rd, 0);
    checkOutput("rst_wbvalid", wb_valid, 0);
    checkOutput("rst_buserr", bus_err, 0);
    checkOutput("rst_misalign", misalign_err, 0);
    checkOutput("rst_stall", lsu_stall, 0);
    rst = 1'b0;
    idleCycle();

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 1, 32'h8012_3456);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h8012_3456);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd8, 1, 32'h8001_3456);
    applyStimulus(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h8001_3456);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h1234_56AB, 5'd0, 1, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h1234_56AB, 5'd0, 2, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0207, 32'h0000_00C3, 5'd3, 1, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h0000_0108, 32'h0, 5'd10, 1, 32'h7654_3210);
    idleCycle();

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd11, 0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'h0, 5'd12, TIMEOUT, 32'h5A5A_A5A5);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'h0BAD_0BAD, 5'd0, 0, 32'h0);
    idleCycle();

    resetMidTransaction();

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h0, 5'd13, 1, 32'h0102_0304);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0504, 32'h0, 5'd14, 1, 32'h0506_0708);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 5'd15, 1, 32'h1357_9BDF);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 5'd16, 1, 32'hF00F_8899);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0103, 32'h89AB_CDEF, 5'd0, 1, 32'h0);
    idleCycle();

    for (int i = 0; i < 40; i++) begin
      f3 = f3Pick[$urandom_range(0, 7)];
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(wr, rd, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(1, 5), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idleCycle();
      end
    end
    idleCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
